// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator datapath family.
package elevator_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_MOVING = 2'd1;
  localparam state_t ST_DOOR   = 2'd2;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

  // Index width for n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Down-counting interval timer shared by the travel and door phases.
module elevator_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/elevator_datapath_dir.sv
// N-floor elevator datapath: call latching, car position/direction tracking,
// travel and door timing, and here/above/below request flags for control.
module elevator_datapath_dir
  import elevator_pkg::*;
#(
  parameter int N_FLOORS    = 8,
  parameter int FLOOR_W     = idx_w(N_FLOORS),
  parameter int MOVE_CYCLES = 3,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] hall_up_btn,
  input  logic [N_FLOORS-1:0] hall_dn_btn,
  input  logic [N_FLOORS-1:0] car_btn,
  input  logic                open,
  input  logic                up,
  input  logic                down,
  output logic [FLOOR_W-1:0]  floor,
  output logic [N_FLOORS-1:0] floor_oh,
  output logic [N_FLOORS-1:0] car_pend,
  output logic [N_FLOORS-1:0] hall_up_pend,
  output logic [N_FLOORS-1:0] hall_dn_pend,
  output logic                request_here,
  output logic                request_above,
  output logic                request_below,
  output logic                busy,
  output logic                arrive,
  output logic                cmd_err
);

  localparam int MAX_CYC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TIMER_W = idx_w(MAX_CYC);
  localparam logic [FLOOR_W-1:0]  TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);
  localparam logic [N_FLOORS-1:0] ONE       = N_FLOORS'(1);
  // No "up" call exists at the top floor and no "down" call at floor 0.
  localparam logic [N_FLOORS-1:0] UP_VALID  = ~(ONE << (N_FLOORS - 1));
  localparam logic [N_FLOORS-1:0] DN_VALID  = ~ONE;

  state_t state;
  dir_t   dir;

  logic               t_load, t_dec, t_zero;
  logic [TIMER_W-1:0] t_load_val;

  logic idle, at_top, at_bot;
  logic open_acc, move_up, move_dn, cmd_bad;
  logic clr_active;
  logic [N_FLOORS-1:0] below_mask, above_mask, all_pend;
  logic [N_FLOORS-1:0] clr_car, clr_up, clr_dn;

  // Thermometer masks derived from the one-hot position.
  assign floor_oh   = ONE << floor;
  assign below_mask = floor_oh - ONE;
  assign above_mask = ~(below_mask | floor_oh);
  assign all_pend   = car_pend | hall_up_pend | hall_dn_pend;

  assign request_here  = |(all_pend & floor_oh);
  assign request_above = |(all_pend & above_mask);
  assign request_below = |(all_pend & below_mask);

  assign idle   = (state == ST_IDLE);
  assign busy   = ~idle;
  assign at_top = (floor == TOP_FLOOR);
  assign at_bot = (floor == '0);

  assign open_acc = idle & open;
  assign move_up  = idle & ~open & up & ~down & ~at_top;
  assign move_dn  = idle & ~open & down & ~up & ~at_bot;
  assign cmd_bad  = idle & ~open & (up | down) & ~move_up & ~move_dn;

  assign t_load     = open_acc | move_up | move_dn;
  assign t_load_val = open_acc ? TIMER_W'(DOOR_CYCLES - 1) : TIMER_W'(MOVE_CYCLES - 1);
  assign t_dec      = busy;

  elevator_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_load_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  // Served calls are cleared on door entry and held clear while the door is
  // open; dir is stable through DOOR so the entry mask is reproduced each cycle.
  assign clr_active = open_acc | (state == ST_DOOR);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    clr_car = '0;
    clr_up  = '0;
    clr_dn  = '0;
    if (clr_active) begin
      clr_car = floor_oh;
      if (dir != DIR_DN) clr_up = floor_oh;
      if (dir != DIR_UP) clr_dn = floor_oh;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      dir          <= DIR_NONE;
      floor        <= '0;
      car_pend     <= '0;
      hall_up_pend <= '0;
      hall_dn_pend <= '0;
      arrive       <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      car_pend     <= (car_pend | car_btn) & ~clr_car;
      hall_up_pend <= (hall_up_pend | (hall_up_btn & UP_VALID)) & ~clr_up;
      hall_dn_pend <= (hall_dn_pend | (hall_dn_btn & DN_VALID)) & ~clr_dn;
      arrive       <= 1'b0;
      cmd_err      <= cmd_bad;

      case (state)
        ST_IDLE: begin
          if (open_acc) begin
            state <= ST_DOOR;
          end else if (move_up) begin
            state <= ST_MOVING;
            dir   <= DIR_UP;
          end else if (move_dn) begin
            state <= ST_MOVING;
            dir   <= DIR_DN;
          end else if (!request_above && !request_below) begin
            dir <= DIR_NONE;
          end
        end
        ST_MOVING: begin
          if (t_zero) begin
            state  <= ST_IDLE;
            arrive <= 1'b1;
            floor  <= (dir == DIR_UP) ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
          end
        end
        ST_DOOR: begin
          if (t_zero) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
